clock_divider_bank: RTL and testbench

Parametrised bank of independent programmable clock dividers. Each channel produces a toggling divided clock and a one-cycle tick strobe from the system clock, with a runtime-loadable divisor. Divisor changes are applied glitch-free at the channel's terminal count. The bank feeds slow-rate logic (display scan, debouncers, baud/sample enables) from one place in the design.

---
 rtl/clock_divider_pkg.sv | 22 ++
 rtl/clock_divider_channel.sv | 89 ++++++++
 rtl/clock_divider_bank.sv | 48 ++++
 tb/tb_clock_divider_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants, helpers and state layout for the clock divider bank.
package clock_divider_pkg;

   localparam int unsigned CNT_WIDTH_DEFAULT = 32;
   localparam logic [31:0] DIV_DEFAULT       = 32'hC350;

   // Width of a channel index; never below one bit so a single-channel bank still has a port.
   function automatic int unsigned ch_idx_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Per-channel state at the default counter width.
   typedef struct packed {
      logic [CNT_WIDTH_DEFAULT-1:0] cnt;
      logic [CNT_WIDTH_DEFAULT-1:0] d_act;
      logic [CNT_WIDTH_DEFAULT-1:0] d_sh;
      logic                         pending;
      logic                         clk;
      logic                         tick;
   } ch_state_t;

endpackage

// File: rtl/clock_divider_channel.sv
// One programmable divider channel: counter, shadow divisor with deferred apply, registered
// divided clock and tick strobe.
module clock_divider_channel
   import clock_divider_pkg::*;
#(
   parameter int unsigned          CNT_WIDTH   = CNT_WIDTH_DEFAULT,
   parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV = CNT_WIDTH'(DIV_DEFAULT)
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 enable,
   input  logic                 sync_restart,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_divisor,
   output logic                 divided_clock,
   output logic                 tick
);

   typedef struct packed {
      logic [CNT_WIDTH-1:0] cnt;
      logic [CNT_WIDTH-1:0] d_act;
      logic [CNT_WIDTH-1:0] d_sh;
      logic                 pending;
      logic                 clk;
      logic                 tick;
   } state_t;

   state_t               st_q, st_d;
   logic                 running;
   logic                 term;
   logic                 has_new;
   logic [CNT_WIDTH-1:0] new_div;

   // Next-state: restart beats terminal count beats counting; a same-edge load wins over
   // an older pending divisor.
   always_comb begin
      st_d      = st_q;
      st_d.tick = 1'b0;
      running   = enable && (st_q.d_act != '0);
      term      = running && (st_q.cnt == st_q.d_act - CNT_WIDTH'(1));
      has_new   = load || st_q.pending;
      new_div   = load ? load_divisor : st_q.d_sh;

      if (load) begin
         st_d.d_sh    = load_divisor;
         st_d.pending = 1'b1;
      end

      if (sync_restart) begin
         st_d.cnt = '0;
         st_d.clk = 1'b0;
         if (has_new) begin
            st_d.d_act   = new_div;
            st_d.pending = 1'b0;
         end
      end else if (!running) begin
         // Disabled or halted: outputs hold, but an already pending divisor goes live now.
         if (st_q.pending) begin
            st_d.d_act   = st_q.d_sh;
            st_d.cnt     = '0;
            st_d.pending = load;
         end
      end else if (term) begin
         st_d.cnt  = '0;
         st_d.clk  = ~st_q.clk;
         st_d.tick = 1'b1;
         if (has_new) begin
            st_d.d_act   = new_div;
            st_d.pending = 1'b0;
         end
      end else begin
         st_d.cnt = st_q.cnt + CNT_WIDTH'(1);
      end
   end

   // State register with asynchronous clear back to the default divisor.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         st_q <= '{cnt: '0, d_act: DEFAULT_DIV, d_sh: DEFAULT_DIV,
                   pending: 1'b0, clk: 1'b0, tick: 1'b0};
      end else begin
         st_q <= st_d;
      end
   end

   assign divided_clock = st_q.clk;
   assign tick          = st_q.tick;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers sharing one divisor load port.
module clock_divider_bank
   import clock_divider_pkg::*;
#(
   parameter int unsigned          NUM_CH      = 4,
   parameter int unsigned          CNT_WIDTH   = CNT_WIDTH_DEFAULT,
   parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV = CNT_WIDTH'(DIV_DEFAULT)
) (
   input  logic                              Clock,
   input  logic                              Reset,
   input  logic [NUM_CH-1:0]                 Enable,
   input  logic                              SyncRestart,
   input  logic                              Load,
   input  logic [ch_idx_width(NUM_CH)-1:0]   LoadChannel,
   input  logic [CNT_WIDTH-1:0]              LoadDivisor,
   output logic [NUM_CH-1:0]                 DividedClock,
   output logic [NUM_CH-1:0]                 Tick
);

   localparam int unsigned CH_W = ch_idx_width(NUM_CH);

   logic [NUM_CH-1:0] ch_load;

   // Decode the load target; an index past the last channel matches nothing.
   always_comb begin
      ch_load = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_load[i] = Load && (LoadChannel == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clock_divider_channel #(
         .CNT_WIDTH   (CNT_WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .Clock         (Clock),
         .Reset         (Reset),
         .enable        (Enable[g]),
         .sync_restart  (SyncRestart),
         .load          (ch_load[g]),
         .load_divisor  (LoadDivisor),
         .divided_clock (DividedClock[g]),
         .tick          (Tick[g])
      );
   end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Table-driven bench for clock_divider_bank with a scoreboard of per-edge expectations.
module tb_clock_divider_bank;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [2:0]  Enable;
   logic        SyncRestart;
   logic        Load;
   logic [1:0]  LoadChannel;
   logic [31:0] LoadDivisor;
   logic [2:0]  DividedClock;
   logic [2:0]  Tick;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  en;
      logic        sr;
      logic        ld;
      logic [1:0]  ch;
      logic [31:0] div;
      logic [2:0]  tick;
      logic [2:0]  clk;
      logic [2:0]  mask;
   } vec_t;

   typedef struct {
      logic [2:0] tick;
      logic [2:0] clk;
      logic [2:0] mask;
      string      tag;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   clock_divider_bank #(
      .NUM_CH      (3),
      .CNT_WIDTH   (32),
      .DEFAULT_DIV (32'd3)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Enable       (Enable),
      .SyncRestart  (SyncRestart),
      .Load         (Load),
      .LoadChannel  (LoadChannel),
      .LoadDivisor  (LoadDivisor),
      .DividedClock (DividedClock),
      .Tick         (Tick)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic add(input logic [2:0] en, input logic sr, input logic ld, input logic [1:0] ch,
                      input logic [31:0] div, input logic [2:0] tk, input logic [2:0] ck,
                      input logic [2:0] mask);
      vec_t v;
      v.en = en; v.sr = sr; v.ld = ld; v.ch = ch; v.div = div;
      v.tick = tk; v.clk = ck; v.mask = mask;
      vecs.push_back(v);
   endtask

   task automatic check(input string tag, input logic [2:0] act, input logic [2:0] exp,
                        input logic [2:0] mask);
      checks++;
      if ((act & mask) !== (exp & mask)) begin
         errors++;
         $display("FAIL %s: got %b expected %b (mask %b)", tag, act, exp, mask);
      end
   endtask

   // Drive one edge's inputs, queue its expectation, then compare just after the edge.
   task automatic step(input vec_t v, input string tag);
      exp_t e;
      Enable      = v.en;
      SyncRestart = v.sr;
      Load        = v.ld;
      LoadChannel = v.ch;
      LoadDivisor = v.div;
      e.tick = v.tick; e.clk = v.clk; e.mask = v.mask; e.tag = tag;
      sb.push_back(e);
      @(posedge Clock);
      #1;
      Load        = 1'b0;
      SyncRestart = 1'b0;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         if (e.mask != 3'b000) begin
            check({e.tag, ".tick"}, Tick, e.tick, e.mask);
            check({e.tag, ".clk"}, DividedClock, e.clk, e.mask);
         end
      end
   endtask

   task automatic run_vecs(input string name);
      for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("%s[%0d]", name, i));
      vecs.delete();
   endtask

   // Default divide-by-3 on all channels, edges 1..n after reset release.
   task automatic fill_default(input int n);
      for (int k = 1; k <= n; k++) begin
         add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, (k % 3 == 0) ? 3'b111 : 3'b000,
             (((k / 3) % 2) != 0) ? 3'b111 : 3'b000, 3'b111);
      end
   endtask

   // First five edges after a restart with ch0 D=1, ch1 D=5, ch2 D=3.
   task automatic fill_post_sync();
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, 3'b001, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, 3'b000, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b101, 3'b101, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, 3'b100, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b011, 3'b111, 3'b111);
   endtask

   initial begin
      Reset = 1'b1; Enable = 3'b111; SyncRestart = 1'b0; Load = 1'b0;
      LoadChannel = 2'd0; LoadDivisor = 32'd0;
      repeat (3) @(posedge Clock);
      #1;
      check("reset.tick", Tick, 3'b000, 3'b111);
      check("reset.clk", DividedClock, 3'b000, 3'b111);
      Reset = 1'b0;

      // Basic divide by the reset default.
      fill_default(9);
      run_vecs("t1");

      // Glitch-free reload on ch0 (4 -> 2), then a load on ch0's terminal edge (2 -> 7).
      add(3'b111, 1'b0, 1'b1, 2'd0, 32'd4, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111);
      add(3'b111, 1'b0, 1'b1, 2'd0, 32'd2, 3'b000, 3'b000, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b110, 3'b110, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, 3'b111, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b111, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b111, 3'b000, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, 3'b001, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b110, 3'b111, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, 3'b110, 3'b111);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b001);
      add(3'b111, 1'b0, 1'b1, 2'd0, 32'd7, 3'b001, 3'b001, 3'b001);
      for (int k = 0; k < 6; k++) add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b001, 3'b001);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, 3'b000, 3'b001);
      run_vecs("t2");

      // Halt (D=0) applied at the next terminal edge, then D=1 applied one edge after load.
      add(3'b111, 1'b0, 1'b1, 2'd0, 32'd0, 3'b000, 3'b000, 3'b001);
      for (int k = 0; k < 5; k++) add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b001);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, 3'b001, 3'b001);
      for (int k = 0; k < 5; k++) add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b001, 3'b001);
      add(3'b111, 1'b0, 1'b1, 2'd0, 32'd1, 3'b000, 3'b001, 3'b001);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b001, 3'b001);
      for (int k = 0; k < 4; k++) begin
         add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b001, (k % 2 == 0) ? 3'b000 : 3'b001, 3'b001);
      end
      run_vecs("t3");

      // ch1 D=5, restart, then freeze ch1 for 7 edges mid-period.
      add(3'b111, 1'b0, 1'b1, 2'd1, 32'd5, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111);
      fill_post_sync();
      for (int k = 0; k < 2; k++) add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b010, 3'b010);
      for (int k = 0; k < 7; k++) add(3'b101, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b010, 3'b010);
      for (int k = 0; k < 2; k++) add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b000, 3'b010, 3'b010);
      add(3'b111, 1'b0, 1'b0, 2'd0, 32'd0, 3'b010, 3'b000, 3'b010);
      run_vecs("t4");

      // Out-of-range load must not reach any channel, even through a restart.
      add(3'b111, 1'b0, 1'b1, 2'd3, 32'd9, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b1, 1'b0, 2'd0, 32'd0, 3'b000, 3'b000, 3'b111);
      fill_post_sync();
      add(3'b111, 1'b0, 1'b1, 2'd2, 32'd6, 3'b000, 3'b000, 3'b000);
      run_vecs("t5");

      // Asynchronous reset mid-period; pending load on ch2 is discarded.
      #2;
      Reset = 1'b1;
      #1;
      check("t5.async.tick", Tick, 3'b000, 3'b111);
      check("t5.async.clk", DividedClock, 3'b000, 3'b111);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      fill_default(6);
      run_vecs("t5.after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
